// File: rtl/acc_req_tracker_pkg.sv
// Shared types and constants for the accelerator request tracker.
// Provides register-file sizing, the response record, the response-register
// state encoding and small index/width helper functions.
package acc_req_tracker_pkg;

    localparam int unsigned NumRegs     = 32'd32;
    localparam int unsigned RegIdxWidth = 32'd5;

    localparam logic [RegIdxWidth-1:0] ZeroReg = 5'd0;
    localparam logic [RegIdxWidth-1:0] LastReg = 5'd31;

    // Response record at the default operand/id widths.
    typedef struct packed {
        logic [0:0]             id;
        logic [RegIdxWidth-1:0] rd;
        logic [31:0]            data0;
        logic [31:0]            data1;
        logic                   dual_writeback;
        logic                   error;
    } acc_tracker_rsp_t;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Bits needed to index num_idx distinct values (at least one bit).
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

    // One-hot mask selecting a single architectural register.
    function automatic logic [NumRegs-1:0] reg_onehot(input logic [RegIdxWidth-1:0] idx);
        return {{(NumRegs-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/acc_req_tracker_scoreboard.sv
// Busy scoreboard for pending destination registers.
// Ports:
//   clk_i/rst_ni            clock, async active-low reset
//   set_*_i                 issue-side update (rd, wb, dual)
//   clr_*_i                 response-side retirement (rd, dual)
//   chk_*_i / hazard_o      hazard lookup for the request at the core port
//   busy_o                  current busy vector (bit 0 always clear)
module acc_tracker_scoreboard
    import acc_req_tracker_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     set_en_i,
    input  logic [RegIdxWidth-1:0]   set_rd_i,
    input  logic                     set_wb_i,
    input  logic                     set_dual_i,
    input  logic                     clr_en_i,
    input  logic [RegIdxWidth-1:0]   clr_rd_i,
    input  logic                     clr_dual_i,
    input  logic [2:0]               chk_rs_valid_i,
    input  logic [3*RegIdxWidth-1:0] chk_rs_i,
    input  logic [RegIdxWidth-1:0]   chk_rd_i,
    input  logic                     chk_wb_i,
    input  logic                     chk_dual_i,
    output logic                     hazard_o,
    output logic [NumRegs-1:0]       busy_o
);

    logic [NumRegs-1:0]     busy_q, busy_d;
    logic [NumRegs-1:0]     set_mask_s, clr_mask_s;
    logic [RegIdxWidth-1:0] set_rd_nxt_s, clr_rd_nxt_s, chk_rd_nxt_s;
    logic                   hazard_s;

    assign set_rd_nxt_s = set_rd_i + 5'd1;
    assign clr_rd_nxt_s = clr_rd_i + 5'd1;
    assign chk_rd_nxt_s = chk_rd_i + 5'd1;

    // Build set/clear masks; the pair partner rd+1 never wraps past r31.
    always_comb begin
        set_mask_s = {NumRegs{1'b0}};
        clr_mask_s = {NumRegs{1'b0}};
        set_mask_s = set_mask_s
                   | ((set_en_i & (set_wb_i | set_dual_i) & (set_rd_i != ZeroReg))
                        ? reg_onehot(set_rd_i) : {NumRegs{1'b0}})
                   | ((set_en_i & set_dual_i & (set_rd_i != LastReg))
                        ? reg_onehot(set_rd_nxt_s) : {NumRegs{1'b0}});
        clr_mask_s = clr_mask_s
                   | (clr_en_i ? reg_onehot(clr_rd_i) : {NumRegs{1'b0}})
                   | ((clr_en_i & clr_dual_i & (clr_rd_i != LastReg))
                        ? reg_onehot(clr_rd_nxt_s) : {NumRegs{1'b0}});
        // Clear first, then set, so a same-cycle issue keeps the register busy.
        busy_d = ((busy_q & ~clr_mask_s) | set_mask_s) & ~reg_onehot(ZeroReg);
    end

    // Hazard lookup against sources and destination(s) of the offered request.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hazard_s = hazard_s
                     | (chk_rs_valid_i[i] & busy_q[chk_rs_i[i*RegIdxWidth +: RegIdxWidth]]);
        end
        hazard_s = hazard_s
                 | ((chk_wb_i | chk_dual_i) & busy_q[chk_rd_i])
                 | (chk_dual_i & (chk_rd_i != LastReg) & busy_q[chk_rd_nxt_s]);
    end

    // Busy vector register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= {NumRegs{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard_o = hazard_s;
    assign busy_o   = busy_q;

endmodule

// File: rtl/acc_req_tracker.sv
// Core-side issue stage in front of an accelerator interconnect requester port.
// Requests pass through combinationally when they carry no register hazard and
// the in-flight limit is not reached; responses return via a one-entry register.
// Ports:
//   core_q_*   request from core (valid/ready, payload, register usage)
//   acc_q_*    forwarded request to interconnect
//   acc_p_*    response from interconnect
//   core_p_*   registered response to core
//   outstanding_o, busy_o, spurious_rsp_o   status
module acc_req_tracker
    import acc_req_tracker_pkg::*;
#(
    parameter int unsigned DataWidth      = 32'd32,
    parameter int unsigned AddrWidth      = 32'd4,
    parameter int unsigned IdWidth        = 32'd1,
    parameter int unsigned MaxOutstanding = 32'd4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   core_q_valid_i,
    output logic                   core_q_ready_o,
    input  logic [AddrWidth-1:0]   core_q_addr_i,
    input  logic [IdWidth-1:0]     core_q_id_i,
    input  logic [31:0]            core_q_data_op_i,
    input  logic [DataWidth-1:0]   core_q_data_arga_i,
    input  logic [DataWidth-1:0]   core_q_data_argb_i,
    input  logic [DataWidth-1:0]   core_q_data_argc_i,
    input  logic [2:0]             core_q_rs_valid_i,
    input  logic [14:0]            core_q_rs_i,
    input  logic [4:0]             core_q_rd_i,
    input  logic                   core_q_wb_i,
    input  logic                   core_q_dual_i,
    output logic                   acc_q_valid_o,
    input  logic                   acc_q_ready_i,
    output logic [AddrWidth-1:0]   acc_q_addr_o,
    output logic [IdWidth-1:0]     acc_q_id_o,
    output logic [31:0]            acc_q_data_op_o,
    output logic [DataWidth-1:0]   acc_q_data_arga_o,
    output logic [DataWidth-1:0]   acc_q_data_argb_o,
    output logic [DataWidth-1:0]   acc_q_data_argc_o,
    input  logic                   acc_p_valid_i,
    output logic                   acc_p_ready_o,
    input  logic [IdWidth-1:0]     acc_p_id_i,
    input  logic [4:0]             acc_p_rd_i,
    input  logic [DataWidth-1:0]   acc_p_data0_i,
    input  logic [DataWidth-1:0]   acc_p_data1_i,
    input  logic                   acc_p_dual_writeback_i,
    input  logic                   acc_p_error_i,
    output logic                   core_p_valid_o,
    input  logic                   core_p_ready_i,
    output logic [IdWidth-1:0]     core_p_id_o,
    output logic [4:0]             core_p_rd_o,
    output logic [DataWidth-1:0]   core_p_data0_o,
    output logic [DataWidth-1:0]   core_p_data1_o,
    output logic                   core_p_dual_writeback_o,
    output logic                   core_p_error_o,
    output logic [3:0]             outstanding_o,
    output logic [31:0]            busy_o,
    output logic                   spurious_rsp_o
);

    localparam int unsigned OutCntWidth = idx_width(MaxOutstanding + 32'd1);

    typedef struct packed {
        logic [IdWidth-1:0]     id;
        logic [RegIdxWidth-1:0] rd;
        logic [DataWidth-1:0]   data0;
        logic [DataWidth-1:0]   data1;
        logic                   dual_writeback;
        logic                   error;
    } rsp_t;

    rsp_state_e             rsp_state_q, rsp_state_d;
    rsp_t                   rsp_q, rsp_d;
    logic [OutCntWidth-1:0] cnt_q, cnt_d;
    logic                   spurious_q, spurious_d;
    logic                   hazard_s, stall_s, issue_fire_s, rsp_accept_s, acc_p_ready_s;
    logic [NumRegs-1:0]     busy_s;

    acc_tracker_scoreboard i_scoreboard (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .set_en_i       (issue_fire_s),
        .set_rd_i       (core_q_rd_i),
        .set_wb_i       (core_q_wb_i),
        .set_dual_i     (core_q_dual_i),
        .clr_en_i       (rsp_accept_s),
        .clr_rd_i       (acc_p_rd_i),
        .clr_dual_i     (acc_p_dual_writeback_i),
        .chk_rs_valid_i (core_q_rs_valid_i),
        .chk_rs_i       (core_q_rs_i),
        .chk_rd_i       (core_q_rd_i),
        .chk_wb_i       (core_q_wb_i),
        .chk_dual_i     (core_q_dual_i),
        .hazard_o       (hazard_s),
        .busy_o         (busy_s)
    );

    assign stall_s       = hazard_s | (cnt_q == OutCntWidth'(MaxOutstanding));
    assign issue_fire_s  = core_q_valid_i & ~stall_s & acc_q_ready_i;
    // The register can take a new response when empty or when it drains this cycle.
    assign acc_p_ready_s = (rsp_state_q == RSP_EMPTY) | core_p_ready_i;
    assign rsp_accept_s  = acc_p_valid_i & acc_p_ready_s;

    assign acc_q_valid_o     = core_q_valid_i & ~stall_s;
    assign core_q_ready_o    = acc_q_ready_i & ~stall_s;
    assign acc_q_addr_o      = core_q_addr_i;
    assign acc_q_id_o        = core_q_id_i;
    assign acc_q_data_op_o   = core_q_data_op_i;
    assign acc_q_data_arga_o = core_q_data_arga_i;
    assign acc_q_data_argb_o = core_q_data_argb_i;
    assign acc_q_data_argc_o = core_q_data_argc_i;

    // Response register next state: hold unless a new response is accepted.
    always_comb begin
        rsp_state_d = rsp_state_q;
        rsp_d       = rsp_q;
        case (rsp_state_q)
            RSP_EMPTY: rsp_state_d = acc_p_valid_i ? RSP_FULL : RSP_EMPTY;
            RSP_FULL:  rsp_state_d = (core_p_ready_i & ~acc_p_valid_i) ? RSP_EMPTY : RSP_FULL;
            default:   rsp_state_d = RSP_EMPTY;
        endcase
        if (rsp_accept_s) begin
            rsp_d.id             = acc_p_id_i;
            rsp_d.rd             = acc_p_rd_i;
            rsp_d.data0          = acc_p_data0_i;
            rsp_d.data1          = acc_p_data1_i;
            rsp_d.dual_writeback = acc_p_dual_writeback_i;
            rsp_d.error          = acc_p_error_i;
        end else begin
            rsp_d = rsp_q;
        end
    end

    // In-flight counter and spurious-response detection.
    always_comb begin
        cnt_d = cnt_q;
        case ({issue_fire_s, rsp_accept_s})
            2'b10:   cnt_d = cnt_q + OutCntWidth'(1);
            2'b01:   cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - OutCntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
        spurious_d = rsp_accept_s
                   & ((cnt_q == '0) | ((acc_p_rd_i != ZeroReg) & ~busy_s[acc_p_rd_i]));
    end

    // State, response and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_state_q <= RSP_EMPTY;
            rsp_q       <= '0;
            cnt_q       <= '0;
            spurious_q  <= 1'b0;
        end else begin
            rsp_state_q <= rsp_state_d;
            rsp_q       <= rsp_d;
            cnt_q       <= cnt_d;
            spurious_q  <= spurious_d;
        end
    end

    assign acc_p_ready_o           = acc_p_ready_s;
    assign core_p_valid_o          = (rsp_state_q == RSP_FULL);
    assign core_p_id_o             = rsp_q.id;
    assign core_p_rd_o             = rsp_q.rd;
    assign core_p_data0_o          = rsp_q.data0;
    assign core_p_data1_o          = rsp_q.data1;
    assign core_p_dual_writeback_o = rsp_q.dual_writeback;
    assign core_p_error_o          = rsp_q.error;
    assign outstanding_o           = 4'(cnt_q);
    assign busy_o                  = busy_s;
    assign spurious_rsp_o          = spurious_q;

endmodule

// File: tb/tb_acc_req_tracker.sv
module tb_acc_req_tracker;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        core_q_valid_i, core_q_ready_o;
    logic [3:0]  core_q_addr_i;
    logic [0:0]  core_q_id_i;
    logic [31:0] core_q_data_op_i, core_q_data_arga_i, core_q_data_argb_i, core_q_data_argc_i;
    logic [2:0]  core_q_rs_valid_i;
    logic [14:0] core_q_rs_i;
    logic [4:0]  core_q_rd_i;
    logic        core_q_wb_i, core_q_dual_i;
    logic        acc_q_valid_o, acc_q_ready_i;
    logic [3:0]  acc_q_addr_o;
    logic [0:0]  acc_q_id_o;
    logic [31:0] acc_q_data_op_o, acc_q_data_arga_o, acc_q_data_argb_o, acc_q_data_argc_o;
    logic        acc_p_valid_i, acc_p_ready_o;
    logic [0:0]  acc_p_id_i;
    logic [4:0]  acc_p_rd_i;
    logic [31:0] acc_p_data0_i, acc_p_data1_i;
    logic        acc_p_dual_writeback_i, acc_p_error_i;
    logic        core_p_valid_o, core_p_ready_i;
    logic [0:0]  core_p_id_o;
    logic [4:0]  core_p_rd_o;
    logic [31:0] core_p_data0_o, core_p_data1_o;
    logic        core_p_dual_writeback_o, core_p_error_o;
    logic [3:0]  outstanding_o;
    logic [31:0] busy_o;
    logic        spurious_rsp_o;

    always #5 clk_i = ~clk_i;

    acc_req_tracker dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_q_valid_i(core_q_valid_i), .core_q_ready_o(core_q_ready_o),
        .core_q_addr_i(core_q_addr_i), .core_q_id_i(core_q_id_i),
        .core_q_data_op_i(core_q_data_op_i), .core_q_data_arga_i(core_q_data_arga_i),
        .core_q_data_argb_i(core_q_data_argb_i), .core_q_data_argc_i(core_q_data_argc_i),
        .core_q_rs_valid_i(core_q_rs_valid_i), .core_q_rs_i(core_q_rs_i),
        .core_q_rd_i(core_q_rd_i), .core_q_wb_i(core_q_wb_i), .core_q_dual_i(core_q_dual_i),
        .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
        .acc_q_addr_o(acc_q_addr_o), .acc_q_id_o(acc_q_id_o),
        .acc_q_data_op_o(acc_q_data_op_o), .acc_q_data_arga_o(acc_q_data_arga_o),
        .acc_q_data_argb_o(acc_q_data_argb_o), .acc_q_data_argc_o(acc_q_data_argc_o),
        .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o),
        .acc_p_id_i(acc_p_id_i), .acc_p_rd_i(acc_p_rd_i),
        .acc_p_data0_i(acc_p_data0_i), .acc_p_data1_i(acc_p_data1_i),
        .acc_p_dual_writeback_i(acc_p_dual_writeback_i), .acc_p_error_i(acc_p_error_i),
        .core_p_valid_o(core_p_valid_o), .core_p_ready_i(core_p_ready_i),
        .core_p_id_o(core_p_id_o), .core_p_rd_o(core_p_rd_o),
        .core_p_data0_o(core_p_data0_o), .core_p_data1_o(core_p_data1_o),
        .core_p_dual_writeback_o(core_p_dual_writeback_o), .core_p_error_o(core_p_error_o),
        .outstanding_o(outstanding_o), .busy_o(busy_o), .spurious_rsp_o(spurious_rsp_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [0:0]  id;
        logic [4:0]  rd;
        logic [31:0] d0, d1;
        logic        dual, err;
    } rsp_rec_t;

    bit       m_busy [32];
    int       m_cnt = 0;
    rsp_rec_t m_rq[$];
    bit       m_spur = 1'b0;
    bit       mon_en = 1'b0;

    function automatic bit m_stall();
        bit s;
        s = (m_cnt == 4);
        for (int i = 0; i < 3; i++)
            if (core_q_rs_valid_i[i] && m_busy[core_q_rs_i[i*5 +: 5]]) s = 1'b1;
        if ((core_q_wb_i || core_q_dual_i) && m_busy[core_q_rd_i]) s = 1'b1;
        if (core_q_dual_i && core_q_rd_i != 5'd31 && m_busy[core_q_rd_i + 1]) s = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    initial forever begin
        @(posedge clk_i or negedge rst_ni);
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_cnt = 0;
            m_rq.delete();
            m_spur = 1'b0;
        end else begin
            bit iss, acc, pop;
            rsp_rec_t r;
            iss = core_q_valid_i && acc_q_ready_i && !m_stall();
            acc = acc_p_valid_i && (m_rq.size() == 0 || core_p_ready_i);
            pop = (m_rq.size() != 0) && core_p_ready_i;
            m_spur = acc && (m_cnt == 0 || (acc_p_rd_i != 5'd0 && !m_busy[acc_p_rd_i]));
            if (acc) begin
                m_busy[acc_p_rd_i] = 1'b0;
                if (acc_p_dual_writeback_i && acc_p_rd_i != 5'd31) m_busy[acc_p_rd_i + 1] = 1'b0;
            end
            if (iss) begin
                if ((core_q_wb_i || core_q_dual_i) && core_q_rd_i != 5'd0) m_busy[core_q_rd_i] = 1'b1;
                if (core_q_dual_i && core_q_rd_i != 5'd31) m_busy[core_q_rd_i + 1] = 1'b1;
            end
            if (iss && !acc) m_cnt++;
            else if (acc && !iss && m_cnt > 0) m_cnt--;
            if (pop) void'(m_rq.pop_front());
            if (acc) begin
                r.id = acc_p_id_i; r.rd = acc_p_rd_i; r.d0 = acc_p_data0_i; r.d1 = acc_p_data1_i;
                r.dual = acc_p_dual_writeback_i; r.err = acc_p_error_i;
                m_rq.push_back(r);
            end
        end
    end

    // Compare every output against the model on the falling edge.
    initial forever begin
        @(negedge clk_i);
        if (mon_en) begin
            bit st;
            st = m_stall();
            chk("m_acc_q_valid", acc_q_valid_o, core_q_valid_i && !st);
            chk("m_core_q_ready", core_q_ready_o, acc_q_ready_i && !st);
            chk("m_acc_p_ready", acc_p_ready_o, m_rq.size() == 0 || core_p_ready_i);
            chk("m_core_p_valid", core_p_valid_o, m_rq.size() != 0);
            if (m_rq.size() != 0) begin
                chk("m_p_data0", core_p_data0_o, m_rq[0].d0);
                chk("m_p_data1", core_p_data1_o, m_rq[0].d1);
                chk("m_p_rd", core_p_rd_o, m_rq[0].rd);
                chk("m_p_id", core_p_id_o, m_rq[0].id);
                chk("m_p_flags", {core_p_dual_writeback_o, core_p_error_o}, {m_rq[0].dual, m_rq[0].err});
            end
            chk("m_busy", busy_o, m_busy_vec());
            chk("m_outstanding", outstanding_o, m_cnt);
            chk("m_spurious", spurious_rsp_o, m_spur);
            chk("m_q_addr", acc_q_addr_o, core_q_addr_i);
            chk("m_q_id", acc_q_id_o, core_q_id_i);
            chk("m_q_op", acc_q_data_op_o, core_q_data_op_i);
            chk("m_q_args", {acc_q_data_arga_o, acc_q_data_argb_o ^ acc_q_data_argc_o},
                {core_q_data_arga_i, core_q_data_argb_i ^ core_q_data_argc_i});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        core_q_valid_i = 1'b0; core_q_rs_valid_i = 3'd0; core_q_rs_i = 15'd0;
        core_q_rd_i = 5'd0; core_q_wb_i = 1'b0; core_q_dual_i = 1'b0;
        acc_q_ready_i = 1'b1; acc_p_valid_i = 1'b0; acc_p_rd_i = 5'd0;
        acc_p_dual_writeback_i = 1'b0; acc_p_error_i = 1'b0; core_p_ready_i = 1'b1;
    endtask

    task automatic req(input logic [4:0] rd, input logic wb, input logic dual);
        core_q_valid_i = 1'b1; core_q_rs_valid_i = 3'd0; core_q_rd_i = rd;
        core_q_wb_i = wb; core_q_dual_i = dual;
        core_q_addr_i = 4'($urandom); core_q_id_i = 1'($urandom);
        core_q_data_op_i = $urandom; core_q_data_arga_i = $urandom;
        core_q_data_argb_i = $urandom; core_q_data_argc_i = $urandom;
    endtask

    task automatic rsp(input logic [4:0] rd, input logic dual, input logic [31:0] d0);
        acc_p_valid_i = 1'b1; acc_p_rd_i = rd; acc_p_dual_writeback_i = dual;
        acc_p_data0_i = d0; acc_p_data1_i = $urandom; acc_p_id_i = 1'($urandom);
        acc_p_error_i = 1'($urandom);
    endtask

    function automatic logic [4:0] pick();
        logic [4:0] v;
        case ($urandom_range(0, 6))
            0: v = 5'd0;  1: v = 5'd1;  2: v = 5'd2;  3: v = 5'd3;
            4: v = 5'd9;  5: v = 5'd30; default: v = 5'd31;
        endcase
        return v;
    endfunction

    function automatic logic [4:0] busy_pick();
        int idx[$];
        for (int i = 0; i < 32; i++) if (m_busy[i]) idx.push_back(i);
        if (idx.size() == 0) return pick();
        return 5'(idx[$urandom_range(0, idx.size() - 1)]);
    endfunction

    typedef struct {
        logic [2:0] rsv;
        logic [4:0] rs0, rs1, rs2, rd;
        logic       wb, dual, exp;
    } hz_vec_t;

    hz_vec_t tbl[14];

    initial begin
        tbl[0]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd5,  1'b0, 1'b0, 1'b1};
        tbl[1]  = '{3'b001, 5'd5, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'b010, 5'd0, 5'd10, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'b100, 5'd0, 5'd0,  5'd11, 5'd0,  1'b0, 1'b0, 1'b0};
        tbl[4]  = '{3'b011, 5'd6, 5'd12, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1};
        tbl[5]  = '{3'b000, 5'd5, 5'd10, 5'd11, 5'd0,  1'b0, 1'b0, 1'b1};
        tbl[6]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0};
        tbl[7]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd6,  1'b1, 1'b0, 1'b1};
        tbl[8]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd4,  1'b0, 1'b1, 1'b0};
        tbl[9]  = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd9,  1'b0, 1'b1, 1'b0};
        tbl[10] = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd12, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd31, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{3'b000, 5'd0, 5'd0,  5'd0,  5'd11, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{3'b110, 5'd0, 5'd9,  5'd5,  5'd0,  1'b0, 1'b0, 1'b0};

        idle();
        req(5'd0, 1'b0, 1'b0); core_q_valid_i = 1'b0;
        acc_p_data0_i = 32'd0; acc_p_data1_i = 32'd0; acc_p_id_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_busy", busy_o, 32'h0);
        chk("reset_cnt", outstanding_o, 4'd0);
        chk("reset_pvalid", core_p_valid_o, 1'b0);
        chk("reset_spur", spurious_rsp_o, 1'b0);
        chk("reset_qvalid", acc_q_valid_o, 1'b0);
        chk("reset_pdata", core_p_data0_o, 32'h0);
        rst_ni = 1'b1;
        mon_en = 1'b1;
        tick();

        // Source hazard on rd=5 until its response retires.
        req(5'd5, 1'b1, 1'b0); #1 chk("A_qvalid", acc_q_valid_o, 1'b1);
        tick();
        chk("A_busy", busy_o, 32'h20);
        chk("A_cnt", outstanding_o, 4'd1);
        core_q_rd_i = 5'd0; core_q_wb_i = 1'b0; core_q_rs_valid_i = 3'b001; core_q_rs_i = 15'd5;
        #1 chk("A_stall", core_q_ready_o, 1'b0);
        tick();
        chk("A_stall2", core_q_ready_o, 1'b0);
        rsp(5'd5, 1'b0, 32'h1111_2222);
        tick();
        acc_p_valid_i = 1'b0;
        #1;
        chk("A_busy_clr", busy_o, 32'h0);
        chk("A_cnt0", outstanding_o, 4'd0);
        chk("A_pvalid", core_p_valid_o, 1'b1);
        chk("A_unstall", core_q_ready_o, 1'b1);
        idle(); tick();

        // Outstanding limit.
        req(5'd0, 1'b0, 1'b0);
        repeat (4) tick();
        chk("B_cnt4", outstanding_o, 4'd4);
        chk("B_stall", acc_q_valid_o, 1'b0);
        rsp(5'd0, 1'b0, 32'h0);
        tick();
        acc_p_valid_i = 1'b0;
        #1;
        chk("B_cnt3", outstanding_o, 4'd3);
        chk("B_fire", acc_q_valid_o, 1'b1);
        tick();
        chk("B_cnt4b", outstanding_o, 4'd4);
        idle();
        rsp(5'd0, 1'b0, 32'h0);
        repeat (4) tick();
        acc_p_valid_i = 1'b0;
        chk("B_drain", outstanding_o, 4'd0);
        chk("B_nospur", spurious_rsp_o, 1'b0);
        tick();

        // Dual writeback.
        req(5'd10, 1'b0, 1'b1); tick(); idle();
        chk("C_busy_dual", busy_o, 32'h0000_0C00);
        rsp(5'd10, 1'b1, 32'h0); tick(); idle();
        chk("C_busy_clr", busy_o, 32'h0);
        req(5'd31, 1'b0, 1'b1); tick(); idle();
        chk("C_busy31", busy_o, 32'h8000_0000);
        rsp(5'd31, 1'b1, 32'h0); tick(); idle();
        chk("C_busy31_clr", busy_o, 32'h0);
        chk("C_cnt", outstanding_o, 4'd0);
        tick();

        // Table of hazard lookups against busy = {5, 10, 11}.
        req(5'd5, 1'b1, 1'b0); tick();
        req(5'd10, 1'b0, 1'b1); tick(); idle();
        chk("T_busy", busy_o, 32'h0000_0C20);
        acc_q_ready_i = 1'b0;
        core_q_valid_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            core_q_rs_valid_i = tbl[i].rsv;
            core_q_rs_i = {tbl[i].rs2, tbl[i].rs1, tbl[i].rs0};
            core_q_rd_i = tbl[i].rd; core_q_wb_i = tbl[i].wb; core_q_dual_i = tbl[i].dual;
            #1;
            chk($sformatf("T%0d_qvalid", i), acc_q_valid_o, tbl[i].exp);
        end
        idle(); tick();
        rsp(5'd5, 1'b0, 32'h0); tick();
        rsp(5'd10, 1'b1, 32'h0); tick(); idle();
        chk("T_clean", busy_o, 32'h0);
        tick();

        // Back-pressured response register.
        core_p_ready_i = 1'b0;
        rsp(5'd7, 1'b0, 32'hA5A5_A5A5); tick();
        rsp(5'd8, 1'b0, 32'h5A5A_5A5A); #1;
        chk("D_pready0", acc_p_ready_o, 1'b0);
        chk("D_first", core_p_data0_o, 32'hA5A5_A5A5);
        tick();
        chk("D_hold", core_p_data0_o, 32'hA5A5_A5A5);
        core_p_ready_i = 1'b1; #1;
        chk("D_pready1", acc_p_ready_o, 1'b1);
        tick();
        acc_p_valid_i = 1'b0; #1;
        chk("D_second", core_p_data0_o, 32'h5A5A_5A5A);
        chk("D_second_v", core_p_valid_o, 1'b1);
        tick();
        chk("D_empty", core_p_valid_o, 1'b0);

        // Spurious responses.
        rsp(5'd7, 1'b0, 32'h7777_7777); tick(); acc_p_valid_i = 1'b0; #1;
        chk("E_spur", spurious_rsp_o, 1'b1);
        chk("E_cnt", outstanding_o, 4'd0);
        chk("E_rd", core_p_rd_o, 5'd7);
        tick();
        chk("E_pulse", spurious_rsp_o, 1'b0);
        req(5'd2, 1'b1, 1'b0); tick(); idle();
        rsp(5'd7, 1'b0, 32'h0); tick(); idle();
        chk("E_spur_busy", spurious_rsp_o, 1'b1);
        chk("E_busy2", busy_o, 32'h4);
        rsp(5'd2, 1'b0, 32'h0); tick(); idle(); tick();

        // Same-cycle issue/retire, then asynchronous reset with two in flight.
        req(5'd0, 1'b0, 1'b0); tick(); idle();
        req(5'd3, 1'b1, 1'b0); rsp(5'd3, 1'b0, 32'h3333_3333); tick(); idle();
        chk("F_busy3", busy_o, 32'h8);
        chk("F_cnt1", outstanding_o, 4'd1);
        req(5'd4, 1'b0, 1'b0); core_p_ready_i = 1'b0; tick(); idle();
        chk("F_cnt2", outstanding_o, 4'd2);
        chk("F_pvalid", core_p_valid_o, 1'b1);
        #1 rst_ni = 1'b0;
        #1;
        chk("F_rst_busy", busy_o, 32'h0);
        chk("F_rst_cnt", outstanding_o, 4'd0);
        chk("F_rst_pvalid", core_p_valid_o, 1'b0);
        chk("F_rst_pdata", core_p_data0_o, 32'h0);
        chk("F_rst_qvalid", acc_q_valid_o, 1'b0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        rsp(5'd7, 1'b0, 32'h0); tick(); idle();
        chk("F_post_spur", spurious_rsp_o, 1'b1);
        tick();

        // Randomized traffic checked by the model on every falling edge.
        for (int c = 0; c < 1500; c++) begin
            core_q_valid_i = 1'($urandom_range(0, 1));
            core_q_addr_i = 4'($urandom); core_q_id_i = 1'($urandom);
            core_q_data_op_i = $urandom; core_q_data_arga_i = $urandom;
            core_q_data_argb_i = $urandom; core_q_data_argc_i = $urandom;
            core_q_rs_valid_i = 3'($urandom);
            core_q_rs_i = {pick(), pick(), pick()};
            core_q_rd_i = pick();
            core_q_wb_i = 1'($urandom_range(0, 1));
            core_q_dual_i = ($urandom_range(0, 3) == 0);
            acc_q_ready_i = ($urandom_range(0, 3) != 0);
            acc_p_valid_i = ($urandom_range(0, 4) < 2);
            acc_p_rd_i = ($urandom_range(0, 1) == 1) ? busy_pick() : pick();
            acc_p_dual_writeback_i = 1'($urandom_range(0, 1));
            acc_p_error_i = 1'($urandom_range(0, 1));
            acc_p_id_i = 1'($urandom);
            acc_p_data0_i = $urandom; acc_p_data1_i = $urandom;
            core_p_ready_i = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
